// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-segment table for the 7-segment scan driver.
package seg7_pkg;

  // Segment vector ordered {g,f,e,d,c,b,a}, active-high form.
  typedef logic [6:0] seg_t;

  // Pattern used for a blanked digit (all segments dark, active-high form).
  localparam seg_t SEG_BLANK = 7'h00;

  // Active-high segment pattern for a hex nibble 0..F.
  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t pattern;
    case (nibble)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      4'hF: pattern = 7'h71;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup lives in the package so the whole slice shares one encoding.
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NUM_DIGITS 7-segment driver with a double-buffered frame.
// A loaded frame waits in the pending buffer and is promoted to the active
// buffer only when the digit index wraps, so a frame never mixes old and new data.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int COMMON_ANODE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    update_pending,
  output logic                    frame_done
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);

  // XOR masks: zero for common cathode, all ones for common anode, so the
  // same mask is both the idle level and the polarity flip.
  localparam seg_t                  SEG_IDLE = (COMMON_ANODE != 0) ? seg_t'(7'h7F) : SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = (COMMON_ANODE != 0) ? '1 : '0;

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] active_digits;
  logic [4*NUM_DIGITS-1:0] pending_digits;
  logic [NUM_DIGITS-1:0]   active_blank;
  logic [NUM_DIGITS-1:0]   pending_blank;

  logic                    slot_end;
  logic                    frame_wrap;
  logic [3:0]              cur_nibble;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   an_sel;
  seg_t                    dec_seg;

  assign slot_end   = enable && (prescaler == PW'(PRESCALE - 1));
  assign frame_wrap = slot_end && (idx == IW'(NUM_DIGITS - 1));

  // Select the active digit nibble, its blank flag and the one-hot select for idx.
  always_comb begin
    cur_nibble = 4'h0;
    cur_blank  = 1'b0;
    an_sel     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nibble = active_digits[i*4 +: 4];
        cur_blank  = active_blank[i];
        an_sel[i]  = 1'b1;
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // Prescaler and digit index advance only while enabled; frame_done marks the wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler  <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (enable) begin
        if (slot_end) begin
          prescaler <= '0;
          idx       <= frame_wrap ? '0 : idx + IW'(1);
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end
    end
  end

  // Pending capture on load, promotion to active at the wrap; a load on the
  // wrap cycle promotes the old pending data and keeps the new frame pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_digits  <= '0;
      pending_digits <= '0;
      active_blank   <= '1;
      pending_blank  <= '1;
      update_pending <= 1'b0;
    end else begin
      if (frame_wrap && update_pending) begin
        active_digits <= pending_digits;
        active_blank  <= pending_blank;
      end
      if (load) begin
        pending_digits <= digits_in;
        pending_blank  <= blank_in;
        update_pending <= 1'b1;
      end else if (frame_wrap) begin
        update_pending <= 1'b0;
      end
    end
  end

  // Registered segment and digit-select outputs, forced idle while scanning is disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= SEG_IDLE;
      an  <= AN_IDLE;
    end else if (!enable) begin
      seg <= SEG_IDLE;
      an  <= AN_IDLE;
    end else begin
      seg <= (cur_blank ? SEG_BLANK : dec_seg) ^ SEG_IDLE;
      an  <= an_sel ^ AN_IDLE;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver (4 digits, prescale 4, common cathode).
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int PS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  blank_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        update_pending;
  logic        frame_done;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t sb[$];

  logic [6:0] hex_table [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .PRESCALE     (PS),
    .COMMON_ANODE (0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .load           (load),
    .digits_in      (digits_in),
    .blank_in       (blank_in),
    .seg            (seg),
    .an             (an),
    .update_pending (update_pending),
    .frame_done     (frame_done)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case something never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] b);
    load      = 1'b1;
    digits_in = d;
    blank_in  = b;
  endtask

  function automatic logic [27:0] frameSegs(input logic [15:0] d, input logic [3:0] b);
    logic [27:0] r;
    r = '0;
    for (int i = 0; i < ND; i++)
      r[i*7 +: 7] = b[i] ? 7'h00 : hex_table[d[i*4 +: 4]];
    return r;
  endfunction

  task automatic expectSlots(input logic [6:0] s, input logic [3:0] a, input int n, input logic lastFd);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.seg = s;
      e.an  = a;
      e.fd  = (i == n - 1) ? lastFd : 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic expectFrame(input logic [27:0] segs);
    for (int d = 0; d < ND; d++)
      expectSlots(segs[d*7 +: 7], 4'b0001 << d, PS, d == ND - 1);
  endtask

  task automatic runCycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      load = 1'b0;
      checkOutput("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("seg", {25'd0, seg}, {25'd0, e.seg});
        checkOutput("an", {28'd0, an}, {28'd0, e.an});
        checkOutput("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
      end
    end
  endtask

  initial begin
    int  n;
    logic fdSeen;

    reset     = 1'b0;
    enable    = 1'b1;
    load      = 1'b0;
    digits_in = '0;
    blank_in  = '0;

    phase = "reset";
    tick();
    tick();
    checkOutput("seg", {25'd0, seg}, 32'h00);
    checkOutput("an", {28'd0, an}, 32'h0);
    checkOutput("update_pending", {31'd0, update_pending}, 32'd0);
    checkOutput("frame_done", {31'd0, frame_done}, 32'd0);

    reset  = 1'b1;
    n      = 0;
    fdSeen = 1'b0;
    for (int i = 0; i < 40 && !fdSeen; i++) begin
      tick();
      n++;
      if (frame_done === 1'b1) fdSeen = 1'b1;
    end
    checkOutput("first_frame_done_latency", n, 32'd16);

    phase = "load1234";
    expectFrame(frameSegs(16'h0000, 4'hF));
    applyStimulus(16'h1234, 4'h0);
    runCycles(1);
    checkOutput("update_pending_set", {31'd0, update_pending}, 32'd1);
    runCycles(14);
    checkOutput("update_pending_hold", {31'd0, update_pending}, 32'd1);
    runCycles(1);
    checkOutput("update_pending_clear", {31'd0, update_pending}, 32'd0);
    expectFrame({7'h06, 7'h5B, 7'h4F, 7'h66});
    runCycles(16);

    phase = "tearing";
    expectFrame(frameSegs(16'h1234, 4'h0));
    applyStimulus(16'h0000, 4'h0);
    runCycles(16);
    expectFrame(frameSegs(16'h0000, 4'h0));
    runCycles(6);
    applyStimulus(16'hFFFF, 4'h0);
    runCycles(1);
    checkOutput("update_pending_mid", {31'd0, update_pending}, 32'd1);
    runCycles(9);
    checkOutput("update_pending_after", {31'd0, update_pending}, 32'd0);
    expectFrame(frameSegs(16'hFFFF, 4'h0));
    runCycles(16);

    phase = "simultaneous";
    expectFrame(frameSegs(16'hFFFF, 4'h0));
    applyStimulus(16'hAAAA, 4'h0);
    runCycles(15);
    applyStimulus(16'hBBBB, 4'h0);
    runCycles(1);
    checkOutput("update_pending_kept", {31'd0, update_pending}, 32'd1);
    expectFrame(frameSegs(16'hAAAA, 4'h0));
    runCycles(16);
    checkOutput("update_pending_done", {31'd0, update_pending}, 32'd0);
    expectFrame(frameSegs(16'hBBBB, 4'h0));
    applyStimulus(16'hBBBB, 4'b0101);
    runCycles(16);

    phase = "blank_enable";
    expectSlots(7'h00, 4'b0001, 4, 1'b0);
    expectSlots(7'h7C, 4'b0010, 1, 1'b0);
    runCycles(5);
    enable = 1'b0;
    expectSlots(7'h00, 4'b0000, 10, 1'b0);
    runCycles(10);
    enable = 1'b1;
    expectSlots(7'h7C, 4'b0010, 3, 1'b0);
    expectSlots(7'h00, 4'b0100, 4, 1'b0);
    expectSlots(7'h7C, 4'b1000, 4, 1'b1);
    runCycles(11);

    phase = "reset_mid";
    expectSlots(7'h00, 4'b0001, 3, 1'b0);
    applyStimulus(16'h1234, 4'h0);
    runCycles(3);
    checkOutput("update_pending_before", {31'd0, update_pending}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("seg_async", {25'd0, seg}, 32'h00);
    checkOutput("an_async", {28'd0, an}, 32'h0);
    checkOutput("update_pending_async", {31'd0, update_pending}, 32'd0);
    tick();
    reset = 1'b1;
    checkOutput("frame_done_reset", {31'd0, frame_done}, 32'd0);
    expectFrame(frameSegs(16'h0000, 4'hF));
    runCycles(16);
    checkOutput("update_pending_discarded", {31'd0, update_pending}, 32'd0);
    expectFrame(frameSegs(16'h0000, 4'hF));
    runCycles(16);

    phase = "end";
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
